mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_timeout.sv | 29 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int ARB_DW          = 32;
   localparam int ARB_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   // True while the shared memory port is owned by a transaction.
   function automatic logic is_busy(input arb_state_t s);
      return (s == DATA) || (s == FETCH);
   endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Ack-wait watchdog: counts cycles spent waiting on the memory port and
// flags the cycle in which the LIMIT-th wait cycle completes.
module mem_arb_timeout
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = ARB_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // Cleared on every grant; saturates so a stuck port cannot wrap it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         cnt <= '0;
      else if (clr)                     cnt <= '0;
      else if (inc && cnt != CW'(LIMIT)) cnt <= cnt + 1'b1;
   end

   // The edge that would bring the count to LIMIT is the expiry edge.
   assign expired = inc && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins over fetch; one transaction at a time; stalls the datapath.
// Optional ack-wait timeout: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ARB_DW-1:0] if_addr,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ARB_DW-1:0] d_addr,
   input  logic [ARB_DW-1:0] d_wdata,
   output logic [ARB_DW-1:0] if_rdata,
   output logic [ARB_DW-1:0] d_rdata,
   output logic              if_valid,
   output logic              d_valid,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ARB_DW-1:0] mem_addr,
   output logic [ARB_DW-1:0] mem_wdata,
   input  logic [ARB_DW-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   arb_state_t        state, state_nx;
   logic [ARB_DW-1:0] addr_q, wdata_q;
   logic              we_q;
   logic              served_d;  // current/last transaction is the data side
   logic              grant;
   logic              to_hit;    // wait limit reached without an ack
   logic              done_hit;

   assign grant    = (state == IDLE) && (if_req || d_req);
   assign done_hit = is_busy(state) && (mem_ack || to_hit);

`ifdef MEM_ARB_TIMEOUT_EN
   logic expired;

   mem_arb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (grant),
      .inc     (is_busy(state)),
      .expired (expired)
   );

   // An ack arriving on the expiry edge still wins.
   assign to_hit = expired && !mem_ack;

   // Sticky error: only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        err <= 1'b0;
      else if (to_hit) err <= 1'b1;
   end
`else
   assign to_hit = 1'b0;
   assign err    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next state: data has priority at grant; DONE always returns to IDLE.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (d_req)       state_nx = DATA;
            else if (if_req) state_nx = FETCH;
         end
         DATA, FETCH: if (done_hit) state_nx = DONE;
         DONE:        state_nx = IDLE;
         default:     state_nx = IDLE;
      endcase
   end

   // Latch the winning request so later input changes cannot disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         served_d <= 1'b0;
      end else if (grant) begin
         served_d <= d_req;
         addr_q   <= d_req ? d_addr : if_addr;
         we_q     <= d_req & d_we;
         wdata_q  <= d_req ? d_wdata : '0;
      end
   end

   // Capture return data; stores leave d_rdata alone, timeouts return 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rdata <= '0;
         d_rdata  <= '0;
      end else if (done_hit) begin
         if (!served_d)  if_rdata <= mem_ack ? mem_rdata : '0;
         else if (!we_q) d_rdata  <= mem_ack ? mem_rdata : '0;
      end
   end

   assign mem_req   = is_busy(state);
   assign mem_we    = mem_req & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_valid  = (state == DONE) && !served_d;
   assign d_valid   = (state == DONE) &&  served_d;
   // Reset gating keeps stall low even while requests are held during reset.
   assign stall     = rst && (mem_req || ((state == IDLE) && (if_req || d_req)));

endmodule
